// File: rtl/gray_pkg.sv
// gray_pkg: shared mode encodings and width-generic Gray conversion helpers
package gray_pkg;
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  localparam int GRAY_MAXW = 64;
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_g2b_stage.sv
// gray_g2b_stage: resolves Gray->binary bits HI..LO of a partially converted word
module gray_g2b_stage #(
  parameter int WIDTH = 4,
  parameter int HI    = WIDTH - 1,
  parameter int LO    = 0
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] word_o,
  output logic             carry_o
);
  // walk the slice MSB-first, each resolved bit becoming the carry for the next
  always_comb begin
    word_o  = word_i;
    carry_o = carry_i;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (i <= HI && i >= LO) begin
        carry_o   = carry_o ^ word_i[i];
        word_o[i] = carry_o;
      end
  end
endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: pipelined bidirectional Gray codec with valid/ready on both sides
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
  logic             advance;
  logic [WIDTH-1:0] data_q [STAGES];
  logic [WIDTH-1:0] data_d [STAGES];
  logic [STAGES-1:0] mode_q, mode_d, valid_q, valid_d, carry_q, carry_d;
  logic             unused_carry;
  assign advance      = !valid_q[STAGES-1] || out_ready;
  assign in_ready     = advance;
  assign out_valid    = valid_q[STAGES-1];
  assign out_mode     = mode_q[STAGES-1];
  assign out_data     = data_q[STAGES-1];
  assign unused_carry = carry_q[STAGES-1];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = WIDTH - 1 - k * CHUNK;
    localparam int LO = WIDTH - (k + 1) * CHUNK > 0 ? WIDTH - (k + 1) * CHUNK : 0;
    logic [WIDTH-1:0] w_in, w_res, w_b2g;
    logic             c_in, m_in;
    if (k == 0) begin : g_head
      assign w_in       = in_data;
      assign c_in       = 1'b0;
      assign m_in       = in_mode;
      assign valid_d[k] = in_valid;
      assign w_b2g      = WIDTH'(bin2gray(GRAY_MAXW'(in_data)));
    end else begin : g_tail
      assign w_in       = data_q[k-1];
      assign c_in       = carry_q[k-1];
      assign m_in       = mode_q[k-1];
      assign valid_d[k] = valid_q[k-1];
      assign w_b2g      = w_in;
    end
    gray_g2b_stage #(.WIDTH(WIDTH), .HI(HI), .LO(LO)) u_slice (
      .word_i (w_in),
      .carry_i(c_in),
      .word_o (w_res),
      .carry_o(carry_d[k])
    );
    assign data_d[k] = m_in == MODE_G2B ? w_res : w_b2g;
    assign mode_d[k] = m_in;
  end
  // whole pipeline shifts together whenever the output slot is free or being drained
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      mode_q  <= '0;
      valid_q <= '0;
      carry_q <= '0;
    end else if (advance) begin
      data_q  <= data_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      carry_q <= carry_d;
    end
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: scoreboard bench for two codec configurations
module tb_gray_codec_pipe;
  localparam int SA = 2;
  localparam int SB = 3;
  typedef struct {logic m; logic [7:0] d; int acc; bit lat;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [3:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
  logic [7:0] b_in_data, b_out_data;
  gray_codec_pipe #(.WIDTH(4), .STAGES(SA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data)
  );
  gray_codec_pipe #(.WIDTH(8), .STAGES(SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data)
  );
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_en = 1'b0;
  bit cap_en = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] cap[$];
  logic [7:0] orig[$];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] m_b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [7:0] m_g2b(input logic [7:0] g);
    for (int v = 0; v < 256; v++) if (m_b2g(8'(v)) == g) return 8'(v);
    return 8'h00;
  endfunction
  function automatic logic [7:0] model(input logic m, input logic [7:0] d);
    return m ? m_g2b(d) : m_b2g(d);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_a(input logic m, input logic [3:0] d, input logic [3:0] e);
    int n = 0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_mode = m; a_in_data = d; a_out_ready = 1'b1;
    #1;
    while (!a_in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (a_in_ready) qa.push_back('{m, {4'h0, e}, cyc, lat_en});
    else chk("a_accept", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask
  task automatic send_b(input logic m, input logic [7:0] d, input logic [7:0] e);
    int n = 0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_mode = m; b_in_data = d; b_out_ready = 1'b1;
    #1;
    while (!b_in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (b_in_ready) qb.push_back('{m, e, cyc, lat_en});
    else chk("b_accept", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
    end
  endtask
  task automatic drain();
    int n = 0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk("drain_left", 32'(qa.size() + qb.size()), 32'd0);
  endtask
  exp_t ea, eb;
  logic [3:0] a_pd;
  logic a_pm;
  bit a_ps = 1'b0;
  always @(negedge clk) begin
    #2;
    if (a_ps && a_out_valid) begin
      chk("a_hold_data", 32'(a_out_data), 32'(a_pd));
      chk("a_hold_mode", 32'(a_out_mode), 32'(a_pm));
    end
    if (a_out_valid && !a_out_ready) chk("a_stall_in_ready", 32'(a_in_ready), 32'd0);
    a_ps = a_out_valid && !a_out_ready; a_pd = a_out_data; a_pm = a_out_mode;
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got data %0h with nothing outstanding", a_out_data);
      end else begin
        ea = qa.pop_front();
        chk("a_data", 32'(a_out_data), 32'(ea.d[3:0]));
        chk("a_mode", 32'(a_out_mode), 32'(ea.m));
        if (ea.lat) chk("a_latency", 32'(cyc - ea.acc), 32'(SA));
      end
    end
  end
  logic [7:0] b_pd;
  logic b_pm;
  bit b_ps = 1'b0;
  always @(negedge clk) begin
    #2;
    if (b_ps && b_out_valid) begin
      chk("b_hold_data", 32'(b_out_data), 32'(b_pd));
      chk("b_hold_mode", 32'(b_out_mode), 32'(b_pm));
    end
    b_ps = b_out_valid && !b_out_ready; b_pd = b_out_data; b_pm = b_out_mode;
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got data %0h with nothing outstanding", b_out_data);
      end else begin
        eb = qb.pop_front();
        chk("b_data", 32'(b_out_data), 32'(eb.d));
        chk("b_mode", 32'(b_out_mode), 32'(eb.m));
        if (eb.lat) chk("b_latency", 32'(cyc - eb.acc), 32'(SB));
        if (cap_en && !eb.m) cap.push_back(b_out_data);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] r;
    a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #3;
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_data", 32'(a_out_data), 32'd0);
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_data", 32'(b_out_data), 32'd0);
    chk("rst_b_mode", 32'(b_out_mode), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_en = 1'b1;
    send_a(1'b0, 4'b1011, 4'b1110);
    send_a(1'b1, 4'b1110, 4'b1011);
    idle(4);
    for (int i = 0; i < 16; i++) begin
      send_a(1'b0, 4'(i), 4'(model(1'b0, 8'(i))));
      send_a(1'b1, 4'(i), 4'(model(1'b1, 8'(i))));
    end
    drain();
    send_a(1'b0, 4'h5, 4'(model(1'b0, 8'h05)));
    idle(1);
    send_a(1'b1, 4'h5, 4'(model(1'b1, 8'h05)));
    drain();
    lat_en = 1'b0;
    send_a(1'b0, 4'h1, 4'(model(1'b0, 8'h01)));
    send_a(1'b1, 4'h2, 4'(model(1'b1, 8'h02)));
    send_a(1'b0, 4'h3, 4'(model(1'b0, 8'h03)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 1'b1; a_in_data = 4'h7;
      #1 chk("a_bp_in_ready", 32'(a_in_ready), 32'd0);
    end
    send_a(1'b1, 4'h7, 4'(model(1'b1, 8'h07)));
    drain();
    lat_en = 1'b1;
    send_b(1'b0, 8'hA5, 8'hF7);
    send_b(1'b1, 8'hF7, 8'hA5);
    drain();
    lat_en = 1'b0;
    cap_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = 8'($urandom);
      orig.push_back(r);
      send_b(1'b0, r, model(1'b0, r));
    end
    drain();
    cap_en = 1'b0;
    chk("b_capture_count", 32'(cap.size()), 32'd1000);
    for (int i = 0; i < 1000 && i < cap.size(); i++) send_b(1'b1, cap[i], orig[i]);
    drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a_in_valid = 1'($urandom); a_in_mode = 1'($urandom); a_in_data = 4'($urandom);
      a_out_ready = $urandom_range(0, 3) != 0;
      b_in_valid = 1'($urandom); b_in_mode = 1'($urandom); b_in_data = 8'($urandom);
      b_out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (a_in_valid && a_in_ready)
        qa.push_back('{a_in_mode, model(a_in_mode, {4'h0, a_in_data}), cyc, 1'b0});
      if (b_in_valid && b_in_ready)
        qb.push_back('{b_in_mode, model(b_in_mode, b_in_data), cyc, 1'b0});
    end
    @(negedge clk);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    drain();
    lat_en = 1'b1;
    send_b(1'b0, 8'h11, model(1'b0, 8'h11));
    send_b(1'b1, 8'h22, model(1'b1, 8'h22));
    @(posedge clk);
    #2;
    chk("b_pre_reset_valid", 32'(b_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("b_reset_valid", 32'(b_out_valid), 32'd0);
    chk("b_reset_data", 32'(b_out_data), 32'd0);
    chk("b_reset_mode", 32'(b_out_mode), 32'd0);
    chk("b_reset_in_ready", 32'(b_in_ready), 32'd1);
    qb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    send_b(1'b0, 8'h01, 8'h01);
    drain();
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
